// File: rtl/cache_fill_arbiter_pkg.sv
// Shared types and constants for the two-client cache line-fill arbiter.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package cache_fill_pkg;

   localparam int ADDR_HI_DEF   = 25;
   localparam int BURST_LEN_DEF = 4;

   typedef logic [2:0] state_t;
   localparam state_t ST_IDLE     = 3'd0;
   localparam state_t ST_ISSUE    = 3'd1;
   localparam state_t ST_WAITDATA = 3'd2;
   localparam state_t ST_BURST    = 3'd3;
   localparam state_t ST_RELEASE  = 3'd4;

   localparam logic GNT_C0 = 1'b0;
   localparam logic GNT_C1 = 1'b1;

   // A lone requester wins outright; on a tie the client not served last time wins
   function automatic logic rr_pick(input logic [1:0] req, input logic last);
      logic g;
      g = ~last;
      if (req == 2'b01) g = GNT_C0;
      if (req == 2'b10) g = GNT_C1;
      return g;
   endfunction

endpackage

// File: rtl/cache_fill_arbiter_if.sv
// Bundles both cache fill ports, the SDRAM burst-read port and status flags.
// Latency: n/a (wiring only).
// Backpressure: n/a; master = arbiter, slave = caches plus SDRAM controller.
interface cache_fill_arbiter_if #(parameter int ADDR_HI = 25);
   logic               c0_req;
   logic [ADDR_HI:1]   c0_addr;
   logic               c0_fill;
   logic [15:0]        c0_data;
   logic               c1_req;
   logic [ADDR_HI:1]   c1_addr;
   logic               c1_fill;
   logic [15:0]        c1_data;
   logic               sdram_req;
   logic [ADDR_HI:1]   sdram_addr;
   logic               sdram_ack;
   logic               sdram_valid;
   logic [15:0]        sdram_data;
   logic               busy;
   logic               proto_err;

   modport master (
      input  c0_req, c0_addr, c1_req, c1_addr, sdram_ack, sdram_valid, sdram_data,
      output c0_fill, c0_data, c1_fill, c1_data, sdram_req, sdram_addr, busy, proto_err
   );

   modport slave (
      output c0_req, c0_addr, c1_req, c1_addr, sdram_ack, sdram_valid, sdram_data,
      input  c0_fill, c0_data, c1_fill, c1_data, sdram_req, sdram_addr, busy, proto_err
   );
endinterface

// File: rtl/cache_fill_arbiter_rr_arb2.sv
// Two-input round-robin picker; remembers the last grant, ties go to the other client.
// Latency: combinational grant, last-grant register updates on the enable strobe.
// Backpressure: none; caller decides when a grant is taken via gnt_en_i.
module rr_arb2
   import cache_fill_pkg::*;
(
   input  logic       clk,
   input  logic       reset_n,
   input  logic [1:0] req_i,
   input  logic       gnt_en_i,
   output logic       gnt_o,
   output logic       gnt_vld_o
);

   logic last_q;

   // Reset to client 1 so client 0 wins the first tie
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)      last_q <= GNT_C1;
      else if (gnt_en_i) last_q <= gnt_o;
   end

   // Grant choice for the current request pattern
   always_comb begin
      gnt_o     = rr_pick(req_i, last_q);
      gnt_vld_o = |req_i;
   end

endmodule

// File: rtl/cache_fill_arbiter.sv
// Shares one SDRAM burst-read port between two caches; optional stats via CACHE_FILL_STATS_EN.
// Latency: one cycle from sdram_valid/sdram_data to the granted client's fill/data.
// Backpressure: none on beats; request held by the cache until its fill, released one cycle after the burst.
module cache_fill_arbiter
   import cache_fill_pkg::*;
#(
   parameter int ADDR_HI   = ADDR_HI_DEF,
   parameter int BURST_LEN = BURST_LEN_DEF
)(
   input  logic clk,
   input  logic reset_n,
   cache_fill_arbiter_if.master bus
`ifdef CACHE_FILL_STATS_EN
   ,
   input  logic        stat_clr,
   output logic [15:0] stat_fills0,
   output logic [15:0] stat_fills1,
   output logic [23:0] stat_stall
`endif
);

   localparam int BW = $clog2(BURST_LEN);
   localparam logic [BW-1:0] BEAT_LAST = BW'(BURST_LEN - 1);

   state_t           state_q, state_d;
   logic             grant_q, grant_d;
   logic             sdram_req_q, sdram_req_d;
   logic [ADDR_HI:1] sdram_addr_q, sdram_addr_d;
   logic             fill0_q, fill0_d, fill1_q, fill1_d;
   logic [15:0]      data0_q, data0_d, data1_q, data1_d;
   logic             busy_q, busy_d;
   logic             err_q, err_d;
   logic [BW-1:0]    beat_q, beat_d;
   logic             grant_c, gnt_vld_c, arb_en;

   rr_arb2 u_arb (
      .clk       (clk),
      .reset_n   (reset_n),
      .req_i     ({bus.c1_req, bus.c0_req}),
      .gnt_en_i  (arb_en),
      .gnt_o     (grant_c),
      .gnt_vld_o (gnt_vld_c)
   );

   // State and all registered outputs
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= ST_IDLE;
         grant_q      <= GNT_C0;
         sdram_req_q  <= 1'b0;
         sdram_addr_q <= '0;
         fill0_q      <= 1'b0;
         fill1_q      <= 1'b0;
         data0_q      <= '0;
         data1_q      <= '0;
         busy_q       <= 1'b0;
         err_q        <= 1'b0;
         beat_q       <= '0;
      end else begin
         state_q      <= state_d;
         grant_q      <= grant_d;
         sdram_req_q  <= sdram_req_d;
         sdram_addr_q <= sdram_addr_d;
         fill0_q      <= fill0_d;
         fill1_q      <= fill1_d;
         data0_q      <= data0_d;
         data1_q      <= data1_d;
         busy_q       <= busy_d;
         err_q        <= err_d;
         beat_q       <= beat_d;
      end
   end

   // Next-state: issue, wait for the first beat, count the rest, then one release cycle
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:     if (gnt_vld_c) state_d = ST_ISSUE;
         ST_ISSUE:    if (bus.sdram_ack) state_d = ST_WAITDATA;
         ST_WAITDATA: if (bus.sdram_valid) state_d = ST_BURST;
         ST_BURST:    if (bus.sdram_valid && beat_q == BEAT_LAST) state_d = ST_RELEASE;
         ST_RELEASE:  state_d = ST_IDLE;
         default:     state_d = ST_IDLE;
      endcase
   end

   // Output next-values: latch grant/address, steer beats, flag gaps inside a burst
   always_comb begin
      arb_en       = 1'b0;
      grant_d      = grant_q;
      sdram_req_d  = sdram_req_q;
      sdram_addr_d = sdram_addr_q;
      fill0_d      = 1'b0;
      fill1_d      = 1'b0;
      data0_d      = data0_q;
      data1_d      = data1_q;
      err_d        = err_q;
      beat_d       = beat_q;
      case (state_q)
         ST_IDLE: begin
            if (gnt_vld_c) begin
               arb_en       = 1'b1;
               grant_d      = grant_c;
               sdram_req_d  = 1'b1;
               sdram_addr_d = grant_c ? bus.c1_addr : bus.c0_addr;
            end
         end
         ST_ISSUE: begin
            if (bus.sdram_ack) sdram_req_d = 1'b0;
         end
         ST_WAITDATA: begin
            if (bus.sdram_valid) begin
               if (grant_q) begin
                  data1_d = bus.sdram_data;
                  fill1_d = 1'b1;
               end else begin
                  data0_d = bus.sdram_data;
                  fill0_d = 1'b1;
               end
               beat_d = BW'(1);
            end
         end
         ST_BURST: begin
            // The cache samples on fixed cycles, so every cycle is forwarded even if not valid
            if (grant_q) data1_d = bus.sdram_data;
            else         data0_d = bus.sdram_data;
            if (bus.sdram_valid) beat_d = beat_q + BW'(1);
            else                 err_d  = 1'b1;
         end
         ST_RELEASE: begin
            beat_d = '0;
         end
         default: ;
      endcase
      busy_d = (state_d != ST_IDLE);
   end

   assign bus.sdram_req  = sdram_req_q;
   assign bus.sdram_addr = sdram_addr_q;
   assign bus.c0_fill    = fill0_q;
   assign bus.c1_fill    = fill1_q;
   assign bus.c0_data    = data0_q;
   assign bus.c1_data    = data1_q;
   assign bus.busy       = busy_q;
   assign bus.proto_err  = err_q;

`ifdef CACHE_FILL_STATS_EN
   logic [15:0] fills0_q, fills1_q;
   logic [23:0] stall_q;
   logic        served0_q, served1_q;
   logic        pending;

   // A request is stalled from assertion until its first fill beat reaches the cache
   assign pending = (bus.c0_req & ~served0_q & ~fill0_q) | (bus.c1_req & ~served1_q & ~fill1_q);

   // Saturating grant and stall counters with synchronous clear
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         fills0_q  <= '0;
         fills1_q  <= '0;
         stall_q   <= '0;
         served0_q <= 1'b0;
         served1_q <= 1'b0;
      end else begin
         served0_q <= bus.c0_req & (served0_q | fill0_q);
         served1_q <= bus.c1_req & (served1_q | fill1_q);
         if (stat_clr) begin
            fills0_q <= '0;
            fills1_q <= '0;
            stall_q  <= '0;
         end else begin
            if (arb_en && !grant_c && fills0_q != 16'hFFFF) fills0_q <= fills0_q + 16'd1;
            if (arb_en &&  grant_c && fills1_q != 16'hFFFF) fills1_q <= fills1_q + 16'd1;
            if (pending && stall_q != 24'hFFFFFF)           stall_q  <= stall_q + 24'd1;
         end
      end
   end

   assign stat_fills0 = fills0_q;
   assign stat_fills1 = fills1_q;
   assign stat_stall  = stall_q;
`endif

endmodule

// File: tb/tb_cache_fill_arbiter.sv
// Directed bench for the cache fill arbiter; stats checks compile in with CACHE_FILL_STATS_EN.
// Latency: inputs driven 2ns after a rising edge, outputs sampled at the same point.
// Backpressure: bench plays both caches and the SDRAM controller.
module tb_cache_fill_arbiter;

   logic clk = 1'b0;
   logic reset_n;
   always #5 clk = ~clk;

   cache_fill_arbiter_if #(.ADDR_HI(25)) bus ();

`ifdef CACHE_FILL_STATS_EN
   logic        stat_clr;
   logic [15:0] stat_fills0, stat_fills1;
   logic [23:0] stat_stall;
`endif

   cache_fill_arbiter dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
`ifdef CACHE_FILL_STATS_EN
      ,
      .stat_clr    (stat_clr),
      .stat_fills0 (stat_fills0),
      .stat_fills1 (stat_fills1),
      .stat_stall  (stat_stall)
`endif
   );

   int          n_tests = 0;
   int          n_fail  = 0;
   logic [15:0] exp_d [2];
   bit          c1_fill_seen;

   always @(negedge clk) if (bus.c1_fill === 1'b1) c1_fill_seen = 1'b1;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #2;
   endtask

   function automatic logic fill_of(input int g);
      return (g == 1) ? bus.c1_fill : bus.c0_fill;
   endfunction

   function automatic logic [15:0] data_of(input int g);
      return (g == 1) ? bus.c1_data : bus.c0_data;
   endfunction

   // One complete fill: grant in IDLE, ack after ack_dly cycles, 4 beats (optional gap), release
   task automatic do_fill(input int g, input logic [24:0] addr, input logic [15:0] base,
                          input int ack_dly, input bit gap);
      int o;
      o = 1 - g;
      tick;
      chk("req_up", bus.sdram_req, 1);
      chk("addr", bus.sdram_addr, addr);
      chk("busy", bus.busy, 1);
      for (int i = 0; i < ack_dly; i++) begin
         tick;
         chk("req_hold", bus.sdram_req, 1);
         chk("addr_hold", bus.sdram_addr, addr);
      end
      bus.sdram_ack = 1'b1;
      tick;
      bus.sdram_ack = 1'b0;
      chk("req_drop", bus.sdram_req, 0);
      for (int b = 0; b < 4; b++) begin
         if (gap && b == 1) begin
            bus.sdram_valid = 1'b0;
            bus.sdram_data  = 16'hDEAD;
            tick;
            exp_d[g] = 16'hDEAD;
            chk("gap_err", bus.proto_err, 1);
            chk("gap_fill", fill_of(g), 0);
            chk("gap_data", data_of(g), exp_d[g]);
         end
         bus.sdram_valid = 1'b1;
         bus.sdram_data  = base + 16'(b);
         if (b == 3) begin
            if (g == 1) bus.c1_req = 1'b0;
            else        bus.c0_req = 1'b0;
         end
         tick;
         exp_d[g] = base + 16'(b);
         chk("fill", fill_of(g), (b == 0));
         chk("data", data_of(g), exp_d[g]);
         chk("other_fill", fill_of(o), 0);
         chk("other_data", data_of(o), exp_d[o]);
      end
      bus.sdram_valid = 1'b0;
      tick;
      chk("busy_release", bus.busy, 0);
   endtask

   initial begin
      reset_n         = 1'b0;
      bus.c0_req      = 1'b0;
      bus.c0_addr     = '0;
      bus.c1_req      = 1'b0;
      bus.c1_addr     = '0;
      bus.sdram_ack   = 1'b0;
      bus.sdram_valid = 1'b0;
      bus.sdram_data  = '0;
`ifdef CACHE_FILL_STATS_EN
      stat_clr        = 1'b0;
`endif
      exp_d[0] = '0;
      exp_d[1] = '0;
      repeat (3) tick;
      reset_n = 1'b1;
      tick;
      chk("rst_req", bus.sdram_req, 0);
      chk("rst_addr", bus.sdram_addr, 0);
      chk("rst_fill0", bus.c0_fill, 0);
      chk("rst_data1", bus.c1_data, 0);
      chk("rst_busy", bus.busy, 0);
      chk("rst_err", bus.proto_err, 0);

      // Simultaneous requests alternate 0,1,0 starting with client 0
      bus.c0_addr = 25'h0000100;
      bus.c1_addr = 25'h0000200;
      bus.c0_req = 1'b1;
      bus.c1_req = 1'b1;
      do_fill(0, 25'h0000100, 16'hA000, 0, 0);
      bus.c0_req = 1'b1;
      do_fill(1, 25'h0000200, 16'hB000, 0, 0);
      bus.c1_req = 1'b1;
      do_fill(0, 25'h0000100, 16'hC000, 0, 0);
      bus.c1_req = 1'b0;

      // Single client 0 with ack after two cycles; client 1 must stay quiet
      c1_fill_seen = 1'b0;
      bus.c0_addr = 25'h0123456;
      bus.c0_req  = 1'b1;
      do_fill(0, 25'h0123456, 16'h1A00, 2, 0);
      chk("c1_fill_never", c1_fill_seen, 0);

      // Stray ack/valid while idle must be ignored
      bus.sdram_ack   = 1'b1;
      bus.sdram_valid = 1'b1;
      tick;
      bus.sdram_ack   = 1'b0;
      bus.sdram_valid = 1'b0;
      chk("stray_busy", bus.busy, 0);
      chk("stray_fill", bus.c0_fill, 0);
      chk("stray_err", bus.proto_err, 0);

      // Late ack on client 1 alone
      bus.c1_addr = 25'h1FFFFFF;
      bus.c1_req  = 1'b1;
      do_fill(1, 25'h1FFFFFF, 16'h2B00, 20, 0);
      chk("err_still_clear", bus.proto_err, 0);

      // Gapped burst on client 0: error is sticky, four beats still land
      bus.c0_addr = 25'h0000007;
      bus.c0_req  = 1'b1;
      do_fill(0, 25'h0000007, 16'h3C00, 1, 1);
      chk("err_sticky", bus.proto_err, 1);

`ifdef CACHE_FILL_STATS_EN
      chk("stat_fills0", stat_fills0, 4);
      chk("stat_fills1", stat_fills1, 2);
      stat_clr = 1'b1;
      tick;
      stat_clr = 1'b0;
      chk("stat_clr_f0", stat_fills0, 0);
      chk("stat_clr_f1", stat_fills1, 0);
      chk("stat_clr_stall", stat_stall, 0);
`endif

      // Reset asserted mid-burst clears everything asynchronously
      bus.c0_addr = 25'h00ABCDE;
      bus.c0_req  = 1'b1;
      tick;
      bus.sdram_ack = 1'b1;
      tick;
      bus.sdram_ack   = 1'b0;
      bus.sdram_valid = 1'b1;
      bus.sdram_data  = 16'h5555;
      tick;
      bus.sdram_data = 16'h5556;
      tick;
      bus.sdram_data = 16'h5557;
      reset_n = 1'b0;
      #1;
      chk("mid_rst_req", bus.sdram_req, 0);
      chk("mid_rst_addr", bus.sdram_addr, 0);
      chk("mid_rst_data0", bus.c0_data, 0);
      chk("mid_rst_busy", bus.busy, 0);
      chk("mid_rst_err", bus.proto_err, 0);
      bus.sdram_valid = 1'b0;
      bus.c0_req      = 1'b0;
      exp_d[0] = '0;
      exp_d[1] = '0;
      tick;
      tick;
      reset_n = 1'b1;
      tick;
      bus.c1_addr = 25'h0055AA0;
      bus.c1_req  = 1'b1;
      do_fill(1, 25'h0055AA0, 16'h7000, 1, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
